// File: rtl/sbus_channel_unpack.sv
// S.BUS frame checker/unpacker: validates header/footer, streams 16 x 11-bit channels, latches flags.
// Latency: strobe at T -> channels T+2..T+17, flags + frame_done T+18, ready for next frame T+19.
// Backpressure: none; a frame strobed while busy is dropped and flagged on overrun. Watchdog: SBUS_WATCHDOG_EN.
module sbus_channel_unpack #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int ERR_W          = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [199:0]     sbus_frame,
    input  logic             sbus_frame_valid,
    output logic             ch_valid,
    output logic [3:0]       ch_idx,
    output logic [10:0]      ch_val,
    output logic             ch17,
    output logic             ch18,
    output logic             frame_lost,
    output logic             failsafe,
    output logic             frame_done,
    output logic             busy,
    output logic             overrun,
    output logic [ERR_W-1:0] err_cnt,
    output logic             link_lost
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        UNPACK = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t             state_q, state_d;
    logic [183:0]       shadow_q, shadow_d;
    logic [4:0]         idx_q, idx_d;
    logic               good_q, good_d;
    logic [3:0]         flags_q, flags_d;
    logic               frame_done_q, frame_done_d;
    logic               overrun_q, overrun_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        idx_d        = idx_q;
        good_d       = good_q;
        flags_d      = flags_q;
        err_cnt_d    = err_cnt_q;
        frame_done_d = 1'b0;
        overrun_d    = sbus_frame_valid && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (sbus_frame_valid) begin
                    shadow_d = sbus_frame[191:8];
                    good_d   = (sbus_frame[7:0] == 8'h0F) && (sbus_frame[199:192] == 8'h00);
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (good_q) begin
                    idx_d   = 5'd0;
                    state_d = UNPACK;
                end else begin
                    if (err_cnt_q != {ERR_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            UNPACK: begin
                // idx 16 is a one-cycle tail so busy covers the frame_done cycle
                if (!idx_q[4]) begin
                    shadow_d = shadow_q >> 11;
                    idx_d    = idx_q + 5'd1;
                    if (idx_q == 5'd15) begin
                        flags_d      = shadow_d[3:0];
                        frame_done_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            idx_q        <= '0;
            good_q       <= 1'b0;
            flags_q      <= 4'b1000;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            idx_q        <= idx_d;
            good_q       <= good_d;
            flags_q      <= flags_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign ch_valid   = (state_q == UNPACK) && !idx_q[4];
    assign ch_idx     = ch_valid ? idx_q[3:0] : 4'd0;
    assign ch_val     = ch_valid ? shadow_q[10:0] : 11'd0;
    assign ch17       = flags_q[0];
    assign ch18       = flags_q[1];
    assign frame_lost = flags_q[2];
    assign failsafe   = flags_q[3];
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;
    assign err_cnt    = err_cnt_q;

`ifdef SBUS_WATCHDOG_EN
    localparam int             WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            link_lost_q;
    logic            check_pass;

    assign check_pass = (state_q == CHECK) && good_q;

    always_comb begin
        wd_d = wd_q;
        if (check_pass) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_q        <= WD_MAX;
            link_lost_q <= 1'b1;
        end else begin
            wd_q        <= wd_d;
            link_lost_q <= (wd_d == WD_MAX);
        end
    end

    assign link_lost = link_lost_q;
`else
    assign link_lost = 1'b0;
`endif

endmodule

// File: tb/tb_sbus_channel_unpack.sv
// Directed bench for sbus_channel_unpack: good/bad frames, overrun, watchdog, mid-frame reset.
module tb_sbus_channel_unpack;

`ifdef SBUS_WATCHDOG_EN
    localparam logic WD_ON = 1'b1;
`else
    localparam logic WD_ON = 1'b0;
`endif

    logic         clk;
    logic         resetn;
    logic [199:0] sbus_frame;
    logic         sbus_frame_valid;
    logic         ch_valid;
    logic [3:0]   ch_idx;
    logic [10:0]  ch_val;
    logic         ch17, ch18, frame_lost, failsafe;
    logic         frame_done, busy, overrun;
    logic [1:0]   err_cnt;
    logic         link_lost;

    int n_tests = 0;
    int n_fail  = 0;

    logic [199:0] frm_garbage;

    sbus_channel_unpack #(.TIMEOUT_CYCLES(100), .ERR_W(2)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .sbus_frame       (sbus_frame),
        .sbus_frame_valid (sbus_frame_valid),
        .ch_valid         (ch_valid),
        .ch_idx           (ch_idx),
        .ch_val           (ch_val),
        .ch17             (ch17),
        .ch18             (ch18),
        .frame_lost       (frame_lost),
        .failsafe         (failsafe),
        .frame_done       (frame_done),
        .busy             (busy),
        .overrun          (overrun),
        .err_cnt          (err_cnt),
        .link_lost        (link_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t required finish earlier", $time);
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [199:0] mk_frame(input logic [7:0] hdr, input logic [15:0][10:0] chs,
                                              input logic [7:0] flags, input logic [7:0] ftr);
        return {ftr, flags, chs, hdr};
    endfunction

    // Call in cycle T (just after an edge): strobes frm, then checks T+1..T+19.
    task automatic run_frame(input logic [199:0] frm, input logic [15:0][10:0] exp_ch,
                             input logic [3:0] exp_flags, input int ovr_at);
        sbus_frame       = frm;
        sbus_frame_valid = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            step();
            sbus_frame_valid = (k == ovr_at);
            if (k == ovr_at) sbus_frame = frm_garbage;
            chk($sformatf("overrun k=%0d", k), overrun, (ovr_at != 0) && (k == ovr_at + 1));
            if (k == 1) begin
                chk("ch_valid check", ch_valid, 0);
                chk("busy check", busy, 1);
            end else if (k <= 17) begin
                chk($sformatf("ch_valid k=%0d", k), ch_valid, 1);
                chk($sformatf("ch_idx k=%0d", k), ch_idx, k - 2);
                chk($sformatf("ch_val[%0d]", k - 2), ch_val, exp_ch[k-2]);
                chk($sformatf("frame_done k=%0d", k), frame_done, 0);
                if (k == 2) chk("link_lost T+2", link_lost, 0);
            end else if (k == 18) begin
                chk("ch_valid T+18", ch_valid, 0);
                chk("frame_done T+18", frame_done, 1);
                chk("busy T+18", busy, 1);
                chk("flags T+18", {failsafe, frame_lost, ch18, ch17}, exp_flags);
            end else begin
                chk("busy T+19", busy, 0);
                chk("frame_done T+19", frame_done, 0);
            end
        end
    endtask

    logic [199:0]      frm_a, frm_b, frm_c;
    logic [15:0][10:0] exp_a, exp_b, chs_g, chs_c;

    initial begin
        resetn           = 1'b0;
        sbus_frame       = '0;
        sbus_frame_valid = 1'b0;

        // Vector A: byte0=0x0F, byte1=0xFF, byte2=0x07 -> ch0=2047, rest 0
        frm_a          = '0;
        frm_a[7:0]     = 8'h0F;
        frm_a[15:8]    = 8'hFF;
        frm_a[23:16]   = 8'h07;
        exp_a          = '0;
        exp_a[0]       = 11'd2047;
        for (int n = 0; n < 16; n++) begin
            exp_b[n] = 11'd1024 + 11'(n);
            chs_g[n] = 11'h123;
            chs_c[n] = 11'd100 + 11'(n * 7);
        end
        frm_b       = mk_frame(8'h0F, exp_b, 8'h0F, 8'h00);
        frm_c       = mk_frame(8'h0F, chs_c, 8'h05, 8'h00);
        frm_garbage = mk_frame(8'h0F, chs_g, 8'h0A, 8'h00);

        step();
        step();
        chk("rst ch_valid", ch_valid, 0);
        chk("rst ch_idx", ch_idx, 0);
        chk("rst ch_val", ch_val, 0);
        chk("rst flags", {failsafe, frame_lost, ch18, ch17}, 4'b1000);
        chk("rst frame_done", frame_done, 0);
        chk("rst busy", busy, 0);
        chk("rst overrun", overrun, 0);
        chk("rst err_cnt", err_cnt, 0);
        chk("rst link_lost", link_lost, WD_ON);
        resetn = 1'b1;
        step();
        chk("post-rst link_lost", link_lost, WD_ON);

        run_frame(frm_a, exp_a, 4'h0, 0);
        run_frame(frm_b, exp_b, 4'hF, 0);

        // Watchdog: cleared at T+2, frame ended at T+19 -> expire at T+102
        for (int i = 0; i < 82; i++) step();
        chk("link_lost T+101", link_lost, 0);
        step();
        chk("link_lost T+102", link_lost, WD_ON);

        // Bad header, then bad footer etc.: 5 rejects saturate a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            sbus_frame       = (i == 1) ? mk_frame(8'h0F, exp_b, 8'h00, 8'h01)
                                        : mk_frame(8'hF0, exp_b, 8'h00, 8'h00);
            sbus_frame_valid = 1'b1;
            step();
            sbus_frame_valid = 1'b0;
            chk($sformatf("bad%0d ch_valid T+1", i), ch_valid, 0);
            chk($sformatf("bad%0d busy T+1", i), busy, 1);
            step();
            chk($sformatf("bad%0d ch_valid T+2", i), ch_valid, 0);
            chk($sformatf("bad%0d busy T+2", i), busy, 0);
            chk($sformatf("bad%0d err_cnt", i), err_cnt, (i + 1 > 3) ? 3 : i + 1);
            chk($sformatf("bad%0d flags", i), {failsafe, frame_lost, ch18, ch17}, 4'hF);
        end

        // Overrun: second strobe at T+5 dropped, first frame intact
        run_frame(frm_c, chs_c, 4'h5, 5);
        step();
        chk("no frame after overrun", busy, 0);

        // Reset mid-UNPACK at T+8
        sbus_frame       = frm_b;
        sbus_frame_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            sbus_frame_valid = 1'b0;
        end
        chk("pre-rst ch_idx", ch_idx, 6);
        chk("pre-rst ch_val", ch_val, 1030);
        resetn = 1'b0;
        #1;
        chk("mid-rst ch_valid", ch_valid, 0);
        chk("mid-rst ch_val", ch_val, 0);
        chk("mid-rst busy", busy, 0);
        chk("mid-rst flags", {failsafe, frame_lost, ch18, ch17}, 4'b1000);
        chk("mid-rst err_cnt", err_cnt, 0);
        chk("mid-rst link_lost", link_lost, WD_ON);
        step();
        step();
        resetn = 1'b1;
        step();
        chk("after-rst ch_valid", ch_valid, 0);
        chk("after-rst busy", busy, 0);
        run_frame(frm_b, exp_b, 4'hF, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
